// File: rtl/alu8_arbiter_pkg.sv
// alu8_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter: FSM state encoding,
// ALU opcode constants, requester-id width and the grant selection helper.
package alu8_arbiter_pkg;

    localparam int ID_W = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_INV = 4'hF;

    // Winner when arbitrating. A lone valid requester always wins; on a tie,
    // fixed priority picks requester 0, round-robin picks the one not granted last.
    function automatic logic [ID_W-1:0] pick_grant(input logic            fixed_prio,
                                                   input logic            v0,
                                                   input logic            v1,
                                                   input logic [ID_W-1:0] last);
        logic [ID_W-1:0] g;
        if (v0 && v1) begin
            g = fixed_prio ? 1'b0 : ~last;
        end else begin
            g = v0 ? 1'b0 : 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/alu8_arbiter_if.sv
// alu8_arbiter_if
// Bundles the two requester channels, the response channel and busy.
//   slave  : the arbiter side (consumes requests, produces responses)
//   master : the requester/consumer side
interface alu8_arbiter_if;
    import alu8_arbiter_pkg::*;

    logic            req0_valid;
    logic [7:0]      req0_a;
    logic [7:0]      req0_b;
    logic [3:0]      req0_op;
    logic            req0_ready;
    logic            req1_valid;
    logic [7:0]      req1_a;
    logic [7:0]      req1_b;
    logic [3:0]      req1_op;
    logic            req1_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [7:0]      rsp_data;
    logic            rsp_of;
    logic            rsp_err;
    logic [ID_W-1:0] rsp_id;
    logic            busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_of, rsp_err, rsp_id, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_of, rsp_err, rsp_id, busy
    );

endinterface

// File: rtl/alu8_arbiter_alu8_bit.sv
// ALU8_bit
// Combinational 8-bit ALU.
//   i_a, i_b : operands          i_op : opcode
//   ALUout   : result, high-Z for opcode 4'hF
//   OF       : signed overflow for add/sub, carry-out for increment, else 0
// Opcodes: 0 and, 1 inc a, 2 add, 3 sub, 4 or, 5 xor, 6 not a, 7 dec a,
//          8 shl a, 9 shr a, 10..14 pass a, 15 invalid (Z)
module ALU8_bit
    import alu8_arbiter_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [3:0] i_op,
    output wire  [7:0] ALUout,
    output logic       OF
);

    logic [7:0] w_res;
    logic [8:0] w_wide;

    // Result and flag selection per opcode
    always_comb begin
        w_res  = 8'h00;
        w_wide = 9'h000;
        OF     = 1'b0;
        case (i_op)
            4'd0: w_res = i_a & i_b;
            4'd1: begin
                w_wide = {1'b0, i_a} + 9'd1;
                w_res  = w_wide[7:0];
                OF     = w_wide[8];
            end
            OP_ADD: begin
                w_res = i_a + i_b;
                OF    = (i_a[7] == i_b[7]) && (w_res[7] != i_a[7]);
            end
            OP_SUB: begin
                w_res = i_a - i_b;
                OF    = (i_a[7] != i_b[7]) && (w_res[7] != i_a[7]);
            end
            4'd4:    w_res = i_a | i_b;
            4'd5:    w_res = i_a ^ i_b;
            4'd6:    w_res = ~i_a;
            4'd7:    w_res = i_a - 8'd1;
            4'd8:    w_res = {i_a[6:0], 1'b0};
            4'd9:    w_res = {1'b0, i_a[7:1]};
            default: w_res = i_a;
        endcase
    end

    assign ALUout = (i_op == OP_INV) ? 8'hzz : w_res;

endmodule

// File: rtl/alu8_arbiter.sv
// alu8_arbiter
// Arbitrates two requesters onto one ALU8_bit and returns a registered result.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu8_arbiter_if.slave (req0/req1 valid/a/b/op/ready,
//              rsp valid/ready/data/of/err/id, busy)
// PRIO_MODE = 0 round-robin on ties, 1 requester 0 always wins.
// Flow: IDLE (grant + latch) -> EXEC (ALU evaluates) -> RESP (hold until rsp_ready).
module alu8_arbiter
    import alu8_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic           clk,
    input  logic           rst,
    alu8_arbiter_if.slave  bus
);

    state_t          r_state;
    state_t          w_next;
    logic [ID_W-1:0] r_last;
    logic [7:0]      r_a;
    logic [7:0]      r_b;
    logic [3:0]      r_op;
    logic [ID_W-1:0] r_id;
    logic            r_rsp_valid;
    logic [7:0]      r_rsp_data;
    logic            r_rsp_of;
    logic            r_rsp_err;
    logic [ID_W-1:0] r_rsp_id;
    logic            w_any;
    logic [ID_W-1:0] w_grant;
    logic            w_ready0;
    logic            w_ready1;
    logic            w_busy;
    wire  [7:0]      w_alu_out;
    wire             w_alu_of;

    assign w_any   = bus.req0_valid | bus.req1_valid;
    assign w_grant = pick_grant(PRIO_MODE != 0, bus.req0_valid, bus.req1_valid, r_last);

    ALU8_bit u_alu (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_op   (r_op),
        .ALUout (w_alu_out),
        .OF     (w_alu_of)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; RESP returns to IDLE, never straight to EXEC
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next = ST_EXEC;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RESP;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM outputs; gated by rst so nothing is accepted or flagged busy during reset
    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        w_busy   = 1'b0;
        if (!rst && (r_state == ST_IDLE)) begin
            w_ready0 = bus.req0_valid && (w_grant == 1'b0);
            w_ready1 = bus.req1_valid && (w_grant == 1'b1);
        end else begin
            w_busy = !rst;
        end
    end

    // Operand latch at grant, result capture in EXEC, response release in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= 1'b1;
            r_a         <= 8'h00;
            r_b         <= 8'h00;
            r_op        <= 4'h0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_rsp_of    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_id    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_a    <= (w_grant == 1'b0) ? bus.req0_a  : bus.req1_a;
                        r_b    <= (w_grant == 1'b0) ? bus.req0_b  : bus.req1_b;
                        r_op   <= (w_grant == 1'b0) ? bus.req0_op : bus.req1_op;
                        r_id   <= w_grant;
                        r_last <= w_grant;
                    end else begin
                        r_last <= r_last;
                    end
                end
                ST_EXEC: begin
                    // Opcode 4'hF leaves the ALU output floating; substitute zero
                    r_rsp_data  <= (r_op == OP_INV) ? 8'h00 : w_alu_out;
                    r_rsp_of    <= ((r_op == OP_ADD) || (r_op == OP_SUB)) ? w_alu_of : 1'b0;
                    r_rsp_err   <= (r_op == OP_INV);
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end else begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.busy       = w_busy;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_of     = r_rsp_of;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.rsp_id     = r_rsp_id;

endmodule

// File: tb/tb_alu8_arbiter.sv
// tb_alu8_arbiter
// Drives one stimulus stream into a round-robin instance (dut_rr) and a
// fixed-priority instance (dut_fp) and checks both against constants and a
// transaction-level reference model.
module tb_alu8_arbiter;
    import alu8_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu8_arbiter_if bus0();
    alu8_arbiter_if bus1();

    assign bus1.req0_valid = bus0.req0_valid;
    assign bus1.req0_a     = bus0.req0_a;
    assign bus1.req0_b     = bus0.req0_b;
    assign bus1.req0_op    = bus0.req0_op;
    assign bus1.req1_valid = bus0.req1_valid;
    assign bus1.req1_a     = bus0.req1_a;
    assign bus1.req1_b     = bus0.req1_b;
    assign bus1.req1_op    = bus0.req1_op;
    assign bus1.rsp_ready  = bus0.rsp_ready;

    alu8_arbiter #(.PRIO_MODE(0)) dut_rr (.clk(clk), .rst(rst), .bus(bus0.slave));
    alu8_arbiter #(.PRIO_MODE(1)) dut_fp (.clk(clk), .rst(rst), .bus(bus1.slave));

    logic       m_r0 [2];
    logic       m_r1 [2];
    logic       m_v  [2];
    logic       m_bz [2];
    logic       m_of [2];
    logic       m_er [2];
    logic       m_id [2];
    logic [7:0] m_d  [2];
    assign m_r0[0] = bus0.req0_ready; assign m_r0[1] = bus1.req0_ready;
    assign m_r1[0] = bus0.req1_ready; assign m_r1[1] = bus1.req1_ready;
    assign m_v[0]  = bus0.rsp_valid;  assign m_v[1]  = bus1.rsp_valid;
    assign m_bz[0] = bus0.busy;       assign m_bz[1] = bus1.busy;
    assign m_of[0] = bus0.rsp_of;     assign m_of[1] = bus1.rsp_of;
    assign m_er[0] = bus0.rsp_err;    assign m_er[1] = bus1.rsp_err;
    assign m_id[0] = bus0.rsp_id[0];  assign m_id[1] = bus1.rsp_id[0];
    assign m_d[0]  = bus0.rsp_data;   assign m_d[1]  = bus1.rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] d;
        logic       of;
        logic       err;
    } vec_t;

    typedef struct packed {
        logic       err;
        logic       of;
        logic [7:0] d;
    } res_t;

    task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", name, m, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        if (id == 0) begin
            bus0.req0_valid = v; bus0.req0_a = a; bus0.req0_b = b; bus0.req0_op = op;
        end else begin
            bus0.req1_valid = v; bus0.req1_a = a; bus0.req1_b = b; bus0.req1_op = op;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Reference ALU written from the opcode definitions with integer arithmetic
    function automatic res_t alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        res_t r;
        int ia, ib, sa, sb, s;
        ia = int'(a); ib = int'(b);
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        r = '0;
        case (op)
            4'd0: r.d = a & b;
            4'd1: r.d = 8'((ia + 1) % 256);
            4'd2: begin s = sa + sb; r.d = 8'((s + 256) % 256); r.of = (s > 127) || (s < -128); end
            4'd3: begin s = sa - sb; r.d = 8'((s + 512) % 256); r.of = (s > 127) || (s < -128); end
            4'd4: r.d = a | b;
            4'd5: r.d = a ^ b;
            4'd6: r.d = 8'(255 - ia);
            4'd7: r.d = 8'((ia + 255) % 256);
            4'd8: r.d = 8'((ia * 2) % 256);
            4'd9: r.d = 8'(ia / 2);
            4'd15: begin r.d = 8'h00; r.err = 1'b1; end
            default: r.d = a;
        endcase
        return r;
    endfunction

    // Single isolated transaction: accept in c0, EXEC in c1, response in c2
    task automatic run_vec(input vec_t v);
        set_req(1 - v.id, 1'b0, 8'h5A, 8'hA5, 4'hF);
        set_req(v.id, 1'b1, v.a, v.b, v.op);
        bus0.rsp_ready = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("vec_ready", m, 32'(v.id == 0 ? m_r0[m] : m_r1[m]), 32'd1);
            chk("vec_other_ready", m, 32'(v.id == 0 ? m_r1[m] : m_r0[m]), 32'd0);
        end
        tick();
        set_req(v.id, 1'b0, 8'h00, 8'h00, 4'h0);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("vec_exec_valid", m, 32'(m_v[m]), 32'd0);
            chk("vec_exec_busy", m, 32'(m_bz[m]), 32'd1);
        end
        tick();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("vec_rsp_valid", m, 32'(m_v[m]), 32'd1);
            chk("vec_rsp_data", m, 32'(m_d[m]), 32'(v.d));
            chk("vec_rsp_of", m, 32'(m_of[m]), 32'(v.of));
            chk("vec_rsp_err", m, 32'(m_er[m]), 32'(v.err));
            chk("vec_rsp_id", m, 32'(m_id[m]), 32'(v.id));
        end
        tick();
    endtask

    vec_t vt [10];
    int   g_id  [2][$];
    int   g_cyc [2][$];

    bit         out_m [2];
    int         acc_m [2];
    int         last_m[2];
    res_t       exp_m [2];
    int         eid_m [2];

    initial begin
        vt[0] = '{0, 8'h41, 8'h00, 4'd1, 8'h42, 1'b0, 1'b0};
        vt[1] = '{0, 8'h7F, 8'h01, 4'd2, 8'h80, 1'b1, 1'b0};
        vt[2] = '{0, 8'h80, 8'h01, 4'd3, 8'h7F, 1'b1, 1'b0};
        vt[3] = '{1, 8'h10, 8'h20, 4'd2, 8'h30, 1'b0, 1'b0};
        vt[4] = '{1, 8'h12, 8'h34, 4'hF, 8'h00, 1'b0, 1'b1};
        vt[5] = '{0, 8'h05, 8'h03, 4'd3, 8'h02, 1'b0, 1'b0};
        vt[6] = '{1, 8'hF0, 8'h3C, 4'd0, 8'h30, 1'b0, 1'b0};
        vt[7] = '{0, 8'hFF, 8'h00, 4'd1, 8'h00, 1'b0, 1'b0};
        vt[8] = '{1, 8'hAA, 8'hFF, 4'd5, 8'h55, 1'b0, 1'b0};
        vt[9] = '{0, 8'h0F, 8'h00, 4'd6, 8'hF0, 1'b0, 1'b0};

        // Reset with both requesters valid: nothing accepted, outputs cleared
        rst = 1'b1;
        set_req(0, 1'b1, 8'h11, 8'h22, 4'd2);
        set_req(1, 1'b1, 8'h33, 8'h44, 4'd3);
        bus0.rsp_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("rst_ready0", m, 32'(m_r0[m]), 32'd0);
            chk("rst_ready1", m, 32'(m_r1[m]), 32'd0);
            chk("rst_busy", m, 32'(m_bz[m]), 32'd0);
            chk("rst_valid", m, 32'(m_v[m]), 32'd0);
            chk("rst_data", m, 32'(m_d[m]), 32'd0);
            chk("rst_flags", m, 32'({m_of[m], m_er[m], m_id[m]}), 32'd0);
        end
        tick();
        rst = 1'b0;
        set_req(0, 1'b0, 8'h00, 8'h00, 4'h0);
        set_req(1, 1'b0, 8'h00, 8'h00, 4'h0);

        foreach (vt[i]) run_vec(vt[i]);

        // Continuous tie: rr alternates 0,1,0,1 every 3 cycles; fp always 0
        reset_dut();
        set_req(0, 1'b1, 8'h01, 8'h02, 4'd2);
        set_req(1, 1'b1, 8'h03, 8'h04, 4'd2);
        bus0.rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (m_r0[m]) begin g_id[m].push_back(0); g_cyc[m].push_back(c); end
                if (m_r1[m]) begin g_id[m].push_back(1); g_cyc[m].push_back(c); end
            end
            tick();
        end
        for (int m = 0; m < 2; m++) begin
            chk("tie_grant_count", m, 32'(g_id[m].size()), 32'd4);
            for (int k = 0; k < g_id[m].size(); k++) begin
                chk("tie_grant_id", m, 32'(g_id[m][k]), (m == 0) ? 32'(k % 2) : 32'd0);
                chk("tie_grant_cycle", m, 32'(g_cyc[m][k]), 32'(3 * k));
            end
        end

        // Stall: result held for 5 cycles with rsp_ready low, no new grant
        reset_dut();
        set_req(0, 1'b1, 8'hFF, 8'h01, OP_ADD);
        set_req(1, 1'b1, 8'h33, 8'h44, 4'd1);
        bus0.rsp_ready = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 2; m++) chk("stall_accept0", m, 32'({m_r0[m], m_r1[m]}), 32'b10);
        tick();
        set_req(0, 1'b0, 8'h00, 8'h00, 4'h0);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                chk("stall_valid", m, 32'(m_v[m]), 32'd1);
                chk("stall_data", m, 32'(m_d[m]), 32'h00);
                chk("stall_of", m, 32'(m_of[m]), 32'd0);
                chk("stall_id", m, 32'(m_id[m]), 32'd0);
                chk("stall_no_grant", m, 32'({m_r0[m], m_r1[m]}), 32'b00);
            end
            tick();
        end
        bus0.rsp_ready = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 2; m++) chk("stall_release_valid", m, 32'(m_v[m]), 32'd1);
        tick();
        @(negedge clk);
        for (int m = 0; m < 2; m++) chk("stall_next_grant1", m, 32'({m_r0[m], m_r1[m]}), 32'b01);
        tick();
        set_req(1, 1'b0, 8'h00, 8'h00, 4'h0);

        // Reset in EXEC abandons the operation; tie afterwards goes to requester 0
        reset_dut();
        set_req(0, 1'b1, 8'h41, 8'h00, 4'd1);
        @(negedge clk);
        for (int m = 0; m < 2; m++) chk("rexec_accept", m, 32'(m_r0[m]), 32'd1);
        tick();
        rst = 1'b1;
        set_req(1, 1'b1, 8'h10, 8'h01, 4'd2);
        @(negedge clk);
        for (int m = 0; m < 2; m++) chk("rexec_during_rst", m, 32'({m_bz[m], m_r0[m], m_r1[m]}), 32'b000);
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("rexec_valid", m, 32'(m_v[m]), 32'd0);
            chk("rexec_busy", m, 32'(m_bz[m]), 32'd0);
            chk("rexec_tie_grant", m, 32'({m_r0[m], m_r1[m]}), 32'b10);
        end
        tick();
        reset_dut();

        // Randomized traffic against the transaction-level model
        for (int m = 0; m < 2; m++) begin
            out_m[m] = 1'b0; acc_m[m] = 0; last_m[m] = 1; eid_m[m] = 0; exp_m[m] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic v0, v1;
            set_req(0, 1'($urandom_range(0, 99) < 55), 8'($urandom), 8'($urandom), 4'($urandom));
            set_req(1, 1'($urandom_range(0, 99) < 55), 8'($urandom), 8'($urandom), 4'($urandom));
            bus0.rsp_ready = 1'($urandom_range(0, 99) < 60);
            @(negedge clk);
            v0 = bus0.req0_valid;
            v1 = bus0.req1_valid;
            for (int m = 0; m < 2; m++) begin
                int g;
                logic e_r0, e_r1, e_v, e_bz;
                g = (v0 && v1) ? ((m == 1) ? 0 : 1 - last_m[m]) : (v0 ? 0 : 1);
                if (!out_m[m]) begin
                    e_r0 = v0 && (g == 0); e_r1 = v1 && (g == 1); e_v = 1'b0; e_bz = 1'b0;
                end else begin
                    e_r0 = 1'b0; e_r1 = 1'b0; e_bz = 1'b1; e_v = (cyc >= acc_m[m] + 2);
                end
                chk("rnd_ready", m, 32'({m_r0[m], m_r1[m]}), 32'({e_r0, e_r1}));
                chk("rnd_valid_busy", m, 32'({m_v[m], m_bz[m]}), 32'({e_v, e_bz}));
                if (e_v) begin
                    chk("rnd_data", m, 32'(m_d[m]), 32'(exp_m[m].d));
                    chk("rnd_of_err_id", m, 32'({m_of[m], m_er[m], m_id[m]}),
                        32'({exp_m[m].of, exp_m[m].err, 1'(eid_m[m])}));
                end
                if (!out_m[m] && (v0 || v1)) begin
                    out_m[m]  = 1'b1;
                    acc_m[m]  = cyc;
                    last_m[m] = g;
                    eid_m[m]  = g;
                    exp_m[m]  = (g == 0) ? alu_ref(bus0.req0_a, bus0.req0_b, bus0.req0_op)
                                         : alu_ref(bus0.req1_a, bus0.req1_b, bus0.req1_op);
                end else if (out_m[m] && e_v && bus0.rsp_ready) begin
                    out_m[m] = 1'b0;
                end
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
